inv_shiftrows_pipe: RTL

Registered AES InvShiftRows stage for the decrypt-direction round datapath. It is the inverse of the codebase's forward ShiftRows byte mapping.
- A 128-bit state enters on a valid/ready handshake.
- The state is permuted and written into a small output FIFO.
- The FIFO drains on a second valid/ready handshake to the next stage (InvSubBytes).
- The FIFO absorbs downstream stalls without dropping states.

---
 rtl/inv_shiftrows_pipe_if.sv | 20 ++
 rtl/inv_shiftrows_pipe.sv | 76 +++++++
 2 files changed

// File: rtl/inv_shiftrows_pipe_if.sv
// Valid/ready bundle for the InvShiftRows stage:
// upstream state input plus downstream head output.
interface inv_shiftrows_pipe_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;

    modport slave (
        input  in_valid, state_in, out_ready,
        output in_ready, out_valid, state_out
    );

    modport master (
        output in_valid, state_in, out_ready,
        input  in_ready, out_valid, state_out
    );
endinterface

// File: rtl/inv_shiftrows_pipe.sv
// AES InvShiftRows stage: combinational byte permutation
// feeding a small output FIFO with valid/ready on both sides.
module inv_shiftrows_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    inv_shiftrows_pipe_if.slave bus,
    output logic [CNT_W-1:0] occupancy,
    output logic             overflow_err
);

    localparam int PW = $clog2(DEPTH);

    logic [127:0]     mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             pending;
    logic [127:0]     perm;
    logic             push;
    logic             pop;

    // Row r rotates right by r columns: o[4c+r] = b[4((c-r)%4)+r]
    assign perm = {
        bus.state_in[31:24],   bus.state_in[55:48],
        bus.state_in[79:72],   bus.state_in[103:96],
        bus.state_in[127:120], bus.state_in[23:16],
        bus.state_in[47:40],   bus.state_in[71:64],
        bus.state_in[95:88],   bus.state_in[119:112],
        bus.state_in[15:8],    bus.state_in[39:32],
        bus.state_in[63:56],   bus.state_in[87:80],
        bus.state_in[111:104], bus.state_in[7:0]
    };

    assign bus.in_ready  = rst_n && (count < CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.state_out = mem[rd_ptr];
    assign occupancy     = count;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending      <= 1'b0;
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= perm;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            // Upstream withdrew a stalled state before it was taken
            pending <= bus.in_valid && !bus.in_ready;
            if (pending && !bus.in_valid) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
